// File: rtl/tpu_tile_ctrl_pkg.sv
// Shared definitions for the systolic tile sequencer: default geometry and FSM states.
package tpu_tile_ctrl_pkg;

    localparam int TILE_AS     = 4;
    localparam int TILE_DIM_W  = 4;
    localparam int TILE_ADDR_W = 10;
    localparam int TILE_DRAIN  = 2 * TILE_AS - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FEED,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

endpackage

// File: rtl/tpu_tile_ctrl_cnt.sv
// Loadable up-counter with terminal-count flag; wraps to zero when it steps past 'last'.
module tpu_loop_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] last,
    output logic [W-1:0] cnt,
    output logic         tc
);

    assign tc = (cnt == last);

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (inc)
            cnt <= tc ? '0 : cnt + W'(1);
    end

endmodule

// File: rtl/tpu_tile_ctrl.sv
// Tile sequencer for the systolic matmul array: walks output tiles column-major,
// streams operand reads, waits for drain, writes result rows and clears the PEs.
module tpu_tile_ctrl
    import tpu_tile_ctrl_pkg::*;
#(
    parameter int ARRAY_SIZE = TILE_AS,
    parameter int DIM_W      = TILE_DIM_W,
    parameter int ADDR_W     = TILE_ADDR_W,
    parameter int DRAIN_CYC  = TILE_DRAIN,
    localparam int RS_W      = $clog2(ARRAY_SIZE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DIM_W-1:0]  m,
    input  logic [DIM_W-1:0]  k,
    input  logic [DIM_W-1:0]  n,
    output logic              done,
    output logic              busy,
    output logic              a_rd_en,
    output logic [ADDR_W-1:0] a_addr,
    output logic              b_rd_en,
    output logic [ADDR_W-1:0] b_addr,
    output logic              pe_clr,
    output logic              out_wr_en,
    output logic [ADDR_W-1:0] out_addr,
    output logic [RS_W-1:0]   out_row_sel
);

    localparam int DR_W = $clog2(DRAIN_CYC);

    state_t            state;
    logic [DIM_W-1:0]  m_q, k_q, mt_q, nt_q;
    logic [ADDR_W-1:0] a_base, b_base, out_cnt;
    logic [DIM_W:0]    mt_sum, nt_sum;

    logic [DIM_W-1:0]  kk, row, col_cnt;
    logic [DR_W-1:0]   dr_cnt;
    logic [RS_W-1:0]   r;
    logic              kk_tc, dr_tc, r_tc, row_tc, col_tc;
    logic              cnt_clr, tile_end, wr_ok;
    logic [DIM_W+RS_W-1:0] row_pos;
    logic              unused;

    // Ceil-divide by the array edge; ARRAY_SIZE is a power of two.
    assign mt_sum   = {1'b0, m} + (DIM_W+1)'(ARRAY_SIZE - 1);
    assign nt_sum   = {1'b0, n} + (DIM_W+1)'(ARRAY_SIZE - 1);
    assign cnt_clr  = (state == S_IDLE);
    assign tile_end = (state == S_WRITE) && r_tc;
    assign row_pos  = {row, r};
    assign wr_ok    = row_pos < (DIM_W+RS_W)'(m_q);
    assign unused   = ^{dr_cnt, col_cnt};

    tpu_loop_cnt #(.W(DIM_W)) u_kk (
        .clk(clk), .rst(rst), .clr(cnt_clr), .inc(state == S_FEED),
        .last(k_q - DIM_W'(1)), .cnt(kk), .tc(kk_tc)
    );

    tpu_loop_cnt #(.W(DR_W)) u_drain (
        .clk(clk), .rst(rst), .clr(cnt_clr), .inc(state == S_DRAIN),
        .last(DR_W'(DRAIN_CYC - 1)), .cnt(dr_cnt), .tc(dr_tc)
    );

    tpu_loop_cnt #(.W(RS_W)) u_row_sel (
        .clk(clk), .rst(rst), .clr(cnt_clr), .inc(state == S_WRITE),
        .last(RS_W'(ARRAY_SIZE - 1)), .cnt(r), .tc(r_tc)
    );

    tpu_loop_cnt #(.W(DIM_W)) u_row_tile (
        .clk(clk), .rst(rst), .clr(cnt_clr), .inc(tile_end),
        .last(mt_q - DIM_W'(1)), .cnt(row), .tc(row_tc)
    );

    tpu_loop_cnt #(.W(DIM_W)) u_col_tile (
        .clk(clk), .rst(rst), .clr(cnt_clr), .inc(tile_end && row_tc),
        .last(nt_q - DIM_W'(1)), .cnt(col_cnt), .tc(col_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            m_q         <= '0;
            k_q         <= '0;
            mt_q        <= '0;
            nt_q        <= '0;
            a_base      <= '0;
            b_base      <= '0;
            out_cnt     <= '0;
            done        <= 1'b0;
            busy        <= 1'b0;
            a_rd_en     <= 1'b0;
            b_rd_en     <= 1'b0;
            a_addr      <= '0;
            b_addr      <= '0;
            pe_clr      <= 1'b0;
            out_wr_en   <= 1'b0;
            out_addr    <= '0;
            out_row_sel <= '0;
        end else begin
            // Outputs are registered from the current state, so they trail it by one cycle.
            done        <= (state == S_DONE);
            busy        <= (state == S_FEED) || (state == S_DRAIN) || (state == S_WRITE);
            a_rd_en     <= 1'b0;
            b_rd_en     <= 1'b0;
            a_addr      <= '0;
            b_addr      <= '0;
            pe_clr      <= 1'b0;
            out_wr_en   <= 1'b0;
            out_addr    <= '0;
            out_row_sel <= '0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        m_q     <= m;
                        k_q     <= k;
                        mt_q    <= DIM_W'(mt_sum >> RS_W);
                        nt_q    <= DIM_W'(nt_sum >> RS_W);
                        a_base  <= '0;
                        b_base  <= '0;
                        out_cnt <= '0;
                        state   <= (m == '0 || k == '0 || n == '0) ? S_DONE : S_FEED;
                    end
                end
                S_FEED: begin
                    a_rd_en <= 1'b1;
                    b_rd_en <= 1'b1;
                    a_addr  <= a_base + ADDR_W'(kk);
                    b_addr  <= b_base + ADDR_W'(kk);
                    if (kk_tc)
                        state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (dr_tc)
                        state <= S_WRITE;
                end
                S_WRITE: begin
                    out_row_sel <= r;
                    // Pad rows of a partial last row tile are skipped, keeping OUT dense.
                    if (wr_ok) begin
                        out_wr_en <= 1'b1;
                        out_addr  <= out_cnt;
                        out_cnt   <= out_cnt + ADDR_W'(1);
                    end
                    if (r_tc) begin
                        pe_clr <= 1'b1;
                        if (row_tc) begin
                            a_base <= '0;
                            b_base <= b_base + ADDR_W'(k_q);
                        end else begin
                            a_base <= a_base + ADDR_W'(k_q);
                        end
                        state <= (row_tc && col_tc) ? S_DONE : S_FEED;
                    end
                end
                S_DONE: begin
                    if (!start)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tpu_tile_ctrl.sv
// Self-checking bench for tpu_tile_ctrl: directed and random jobs against a per-cycle
// reference computed from tile index / phase arithmetic.
module tb_tpu_tile_ctrl;

    logic       clk = 1'b0;
    logic       rst, start;
    logic [3:0] m, k, n;
    logic       done, busy, a_rd_en, b_rd_en, pe_clr, out_wr_en;
    logic [9:0] a_addr, b_addr, out_addr;
    logic [1:0] out_row_sel;

    int total = 0;
    int bad   = 0;
    int cur_t = 0;

    typedef struct {
        bit rd; int a; int b;
        bit wr; int oa;
        bit wph; int rs;
        bit clr; bit dn; bit bz;
    } exp_t;

    tpu_tile_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .m(m), .k(k), .n(n),
        .done(done), .busy(busy),
        .a_rd_en(a_rd_en), .a_addr(a_addr), .b_rd_en(b_rd_en), .b_addr(b_addr),
        .pe_clr(pe_clr), .out_wr_en(out_wr_en), .out_addr(out_addr),
        .out_row_sel(out_row_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s t=%0d got=%0d exp=%0d", tag, cur_t, obs, exp);
        end
    endtask

    // Expected outputs t cycles after the start-sample edge.
    function automatic exp_t model(input int jm, input int jk, input int jn, input int t);
        exp_t e;
        int mt, nt, len, tiles, u, tile, ph, row, col, r;
        e = '{default: 0};
        mt = (jm + 3) / 4;
        nt = (jn + 3) / 4;
        len = jk + 7 + 4;
        tiles = (jm == 0 || jk == 0 || jn == 0) ? 0 : mt * nt;
        if (t >= 1 + tiles * len) begin
            e.dn = 1'b1;
            return e;
        end
        u = t - 1;
        tile = u / len;
        ph = u % len;
        col = tile / mt;
        row = tile % mt;
        e.bz = 1'b1;
        if (ph < jk) begin
            e.rd = 1'b1;
            e.a = row * jk + ph;
            e.b = col * jk + ph;
        end else if (ph >= jk + 7) begin
            r = ph - jk - 7;
            e.wph = 1'b1;
            e.rs = r;
            e.wr = (row * 4 + r) < jm;
            e.oa = col * jm + row * 4 + r;
            e.clr = (r == 3);
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".rd"}, {31'd0, a_rd_en | b_rd_en}, 0);
        chk({tag, ".wr"}, {31'd0, out_wr_en}, 0);
        chk({tag, ".clr"}, {31'd0, pe_clr}, 0);
        chk({tag, ".done"}, {31'd0, done}, 0);
        chk({tag, ".busy"}, {31'd0, busy}, 0);
    endtask

    // One complete job from IDLE; hold keeps start high throughout, poke disturbs start/dims mid-job.
    task automatic run_job(input int jm, input int jk, input int jn, input bit hold, input bit poke);
        exp_t e;
        int tiles, last_t, nwr, nclr, last_oa;
        tiles = (jm == 0 || jk == 0 || jn == 0) ? 0 : ((jm + 3) / 4) * ((jn + 3) / 4);
        last_t = 1 + tiles * (jk + 11);
        nwr = 0; nclr = 0; last_oa = -1;
        m = 4'(jm); k = 4'(jk); n = 4'(jn);
        start = 1'b1;
        tick();
        if (!hold) start = 1'b0;
        for (int t = 1; t <= last_t + 3; t++) begin
            if (poke && t == 2 && tiles > 0) begin
                start = 1'b1;
                m = 4'($urandom); k = 4'($urandom); n = 4'($urandom);
            end else if (poke && t == 3 && !hold) begin
                start = 1'b0;
            end
            tick();
            cur_t = t;
            if (!hold && t > last_t) break;
            e = model(jm, jk, jn, t);
            chk("a_rd_en", {31'd0, a_rd_en}, {31'd0, e.rd});
            chk("b_rd_en", {31'd0, b_rd_en}, {31'd0, e.rd});
            if (e.rd) begin
                chk("a_addr", {22'd0, a_addr}, e.a);
                chk("b_addr", {22'd0, b_addr}, e.b);
            end
            chk("out_wr_en", {31'd0, out_wr_en}, {31'd0, e.wr});
            if (e.wr) chk("out_addr", {22'd0, out_addr}, e.oa);
            if (e.wph) chk("out_row_sel", {30'd0, out_row_sel}, e.rs);
            chk("pe_clr", {31'd0, pe_clr}, {31'd0, e.clr});
            chk("done", {31'd0, done}, {31'd0, e.dn});
            chk("busy", {31'd0, busy}, {31'd0, e.bz});
            if (out_wr_en === 1'b1) begin nwr++; last_oa = int'(out_addr); end
            if (pe_clr === 1'b1) nclr++;
        end
        chk("write_count", nwr, jm * ((jn + 3) / 4) * (tiles > 0 ? 1 : 0));
        chk("clr_count", nclr, tiles);
        if (nwr > 0) chk("last_out_addr", last_oa, nwr - 1);
        start = 1'b0;
        tick();
        tick();
        cur_t = -1;
        chk_quiet("idle_after");
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; m = '0; k = '0; n = '0;
        tick();
        tick();
        cur_t = 0;
        chk_quiet("reset");
        chk("reset.a_addr", {22'd0, a_addr}, 0);
        chk("reset.out_addr", {22'd0, out_addr}, 0);
        rst = 1'b0;
        tick();

        run_job(4, 4, 4, 1'b1, 1'b0);
        run_job(9, 3, 5, 1'b0, 1'b0);
        run_job(0, 5, 6, 1'b0, 1'b0);

        // Reset during the second FEED cycle of an 8x8x8 job.
        m = 4'd8; k = 4'd8; n = 4'd8; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        cur_t = 1;
        chk("mid_rst.pre_rd", {31'd0, a_rd_en}, 1);
        rst = 1'b1;
        tick();
        cur_t = 2;
        chk_quiet("mid_rst");
        chk("mid_rst.row_sel", {30'd0, out_row_sel}, 0);
        chk("mid_rst.a_addr", {22'd0, a_addr}, 0);
        rst = 1'b0;
        tick();
        chk_quiet("post_rst");
        run_job(4, 4, 4, 1'b1, 1'b0);

        run_job(6, 2, 7, 1'b1, 1'b1);
        run_job(5, 3, 4, 1'b0, 1'b1);
        run_job(15, 15, 15, 1'b0, 1'b0);
        run_job(1, 1, 1, 1'b0, 1'b0);
        run_job(3, 0, 2, 1'b1, 1'b0);

        for (int i = 0; i < 10; i++) begin
            run_job(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 15)), 1'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
